// File: rtl/tinysnn_pkg.sv
// Shared types and constants for the tinysnn receive-side spike decoder.
package tinysnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2
    } dec_state_t;

    localparam int unsigned SPIKE_CNT_W   = 8;
    localparam int unsigned SPIKE_CNT_MAX = 255;
    localparam int unsigned WIN_CNT_W     = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear, load-one and increment (priority in that order).
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = WIDTH'(1);
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Recovers a rate value from a spike train by counting rising edges per window,
// and measures the inter-spike interval between consecutive events.
module spike_rate_decoder
    import tinysnn_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 256,
    parameter int unsigned ISI_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic             clear,
    output logic [7:0]       rate,
    output logic             rate_sat,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);

    localparam logic [WIN_CNT_W-1:0]   WIN_LAST = WIN_CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [SPIKE_CNT_W-1:0] SPK_MAX  = SPIKE_CNT_W'(SPIKE_CNT_MAX);

    dec_state_t             state_q;
    logic                   spike_q;
    logic [WIN_CNT_W-1:0]   win_q;
    logic [SPIKE_CNT_W-1:0] spk_cnt;
    logic [ISI_W-1:0]       isi_cnt;

    logic                   run_c;
    logic                   event_c;
    logic                   win_end_c;
    logic [SPIKE_CNT_W-1:0] spk_final_c;
    logic                   spk_clr_c;
    logic                   isi_clr_c;
    logic                   isi_inc_c;

    // Decode qualifiers: run_c is high only in an active state with no clear pending.
    always_comb begin
        run_c       = 1'b0;
        event_c     = 1'b0;
        win_end_c   = 1'b0;
        spk_final_c = spk_cnt;
        spk_clr_c   = 1'b1;
        isi_clr_c   = 1'b1;
        isi_inc_c   = 1'b0;

        run_c     = ena && (state_q != IDLE) && !clear;
        event_c   = run_c && spike_in && !spike_q;
        win_end_c = run_c && (win_q == WIN_LAST);

        // Count seen by the window end includes an event in the same cycle.
        if (event_c && (spk_cnt != SPK_MAX)) begin
            spk_final_c = spk_cnt + SPIKE_CNT_W'(1);
        end

        spk_clr_c = !run_c || win_end_c;
        isi_clr_c = !run_c;
        isi_inc_c = run_c && (state_q == TRACK);
    end

    sat_counter #(
        .WIDTH (SPIKE_CNT_W)
    ) u_spike_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (spk_clr_c),
        .load1_i (1'b0),
        .inc_i   (event_c),
        .cnt_o   (spk_cnt)
    );

    sat_counter #(
        .WIDTH (ISI_W)
    ) u_isi_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (isi_clr_c),
        .load1_i (event_c),
        .inc_i   (isi_inc_c),
        .cnt_o   (isi_cnt)
    );

    // State, edge-detect register, window counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            spike_q    <= 1'b0;
            win_q      <= '0;
            rate       <= '0;
            rate_sat   <= 1'b0;
            rate_valid <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            isi_valid  <= 1'b0;
            if (!ena) begin
                state_q <= IDLE;
                spike_q <= 1'b0;
                win_q   <= '0;
            end else begin
                spike_q <= spike_in;
                if ((state_q == IDLE) || clear) begin
                    state_q <= ARMED;
                    win_q   <= '0;
                end else begin
                    win_q <= win_end_c ? '0 : (win_q + WIN_CNT_W'(1));
                    if (win_end_c) begin
                        rate       <= spk_final_c;
                        rate_sat   <= (spk_final_c == SPK_MAX);
                        rate_valid <= 1'b1;
                    end
                    if (event_c) begin
                        state_q <= TRACK;
                        if (state_q == TRACK) begin
                            isi       <= isi_cnt;
                            isi_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: a W=16 instance (A) and a W=600 instance (B).
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst_n;

    logic       ena_a, spike_a, clear_a;
    logic [7:0] rate_a;
    logic       rate_sat_a, rate_valid_a;
    logic [7:0] isi_a;
    logic       isi_valid_a;

    logic       ena_b, spike_b, clear_b;
    logic [7:0] rate_b;
    logic       rate_sat_b, rate_valid_b;
    logic [7:0] isi_b;
    logic       isi_valid_b;

    logic [8:0] exp_rate_a[$];
    logic [7:0] exp_isi_a[$];
    logic [8:0] exp_rate_b[$];
    logic [7:0] exp_isi_b[$];

    int checks;
    int failures;

    spike_rate_decoder #(.WINDOW_CYCLES(16), .ISI_W(8)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena_a),
        .spike_in   (spike_a),
        .clear      (clear_a),
        .rate       (rate_a),
        .rate_sat   (rate_sat_a),
        .rate_valid (rate_valid_a),
        .isi        (isi_a),
        .isi_valid  (isi_valid_a)
    );

    spike_rate_decoder #(.WINDOW_CYCLES(600), .ISI_W(8)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena_b),
        .spike_in   (spike_b),
        .clear      (clear_b),
        .rate       (rate_b),
        .rate_sat   (rate_sat_b),
        .rate_valid (rate_valid_b),
        .isi        (isi_b),
        .isi_valid  (isi_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge and retire any valid pulses against the scoreboard.
    task automatic tick();
        logic [8:0] er;
        logic [7:0] ei;
        @(negedge clk);
        if (rate_valid_a) begin
            checks++;
            if (exp_rate_a.size() == 0) begin
                failures++;
                $display("FAIL rate_a_unexpected: got rate=%0d sat=%0d, required no pulse", rate_a, rate_sat_a);
            end else begin
                er = exp_rate_a.pop_front();
                if ({rate_sat_a, rate_a} !== er) begin
                    failures++;
                    $display("FAIL rate_a: got sat=%0d rate=%0d, required sat=%0d rate=%0d",
                             rate_sat_a, rate_a, er[8], er[7:0]);
                end
            end
        end
        if (isi_valid_a) begin
            checks++;
            if (exp_isi_a.size() == 0) begin
                failures++;
                $display("FAIL isi_a_unexpected: got isi=%0d, required no pulse", isi_a);
            end else begin
                ei = exp_isi_a.pop_front();
                if (isi_a !== ei) begin
                    failures++;
                    $display("FAIL isi_a: got %0d, required %0d", isi_a, ei);
                end
            end
        end
        if (rate_valid_b) begin
            checks++;
            if (exp_rate_b.size() == 0) begin
                failures++;
                $display("FAIL rate_b_unexpected: got rate=%0d sat=%0d, required no pulse", rate_b, rate_sat_b);
            end else begin
                er = exp_rate_b.pop_front();
                if ({rate_sat_b, rate_b} !== er) begin
                    failures++;
                    $display("FAIL rate_b: got sat=%0d rate=%0d, required sat=%0d rate=%0d",
                             rate_sat_b, rate_b, er[8], er[7:0]);
                end
            end
        end
        if (isi_valid_b) begin
            checks++;
            if (exp_isi_b.size() == 0) begin
                failures++;
                $display("FAIL isi_b_unexpected: got isi=%0d, required no pulse", isi_b);
            end else begin
                ei = exp_isi_b.pop_front();
                if (isi_b !== ei) begin
                    failures++;
                    $display("FAIL isi_b: got %0d, required %0d", isi_b, ei);
                end
            end
        end
    endtask

    // Park A in IDLE; the caller's first tick after this is edge 1.
    task automatic start_a();
        ena_a   = 1'b0;
        spike_a = 1'b0;
        clear_a = 1'b0;
        tick();
        tick();
        ena_a = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena_a = 1'b0; spike_a = 1'b0; clear_a = 1'b0;
        ena_b = 1'b0; spike_b = 1'b0; clear_b = 1'b0;
        repeat (3) @(negedge clk);
        checks += 2;
        if ({rate_a, rate_sat_a, rate_valid_a, isi_a, isi_valid_a} !== 19'd0) begin
            failures++;
            $display("FAIL reset_a: got rate=%0d sat=%0d rv=%0d isi=%0d iv=%0d, required all 0",
                     rate_a, rate_sat_a, rate_valid_a, isi_a, isi_valid_a);
        end
        if ({rate_b, rate_sat_b, rate_valid_b, isi_b, isi_valid_b} !== 19'd0) begin
            failures++;
            $display("FAIL reset_b: got rate=%0d sat=%0d rv=%0d isi=%0d iv=%0d, required all 0",
                     rate_b, rate_sat_b, rate_valid_b, isi_b, isi_valid_b);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_period();
        start_a();
        repeat (3) exp_rate_a.push_back({1'b0, 8'd4});
        repeat (11) exp_isi_a.push_back(8'd4);
        for (int e = 1; e <= 49; e++) begin
            spike_a = (e >= 2) && ((e - 2) % 4 == 0);
            tick();
        end
        spike_a = 1'b0;
        ena_a   = 1'b0;
        tick();
        checks++;
        if (exp_rate_a.size() != 0 || exp_isi_a.size() != 0) begin
            failures++;
            $display("FAIL fixed_period_drain: got %0d rate / %0d isi pending, required 0",
                     exp_rate_a.size(), exp_isi_a.size());
        end
    endtask

    task automatic test_saturation();
        ena_b = 1'b0; spike_b = 1'b0; clear_b = 1'b0;
        tick();
        tick();
        ena_b = 1'b1;
        exp_rate_b.push_back({1'b1, 8'd255});
        exp_rate_b.push_back({1'b0, 8'd3});
        repeat (299) exp_isi_b.push_back(8'd2);
        repeat (3) exp_isi_b.push_back(8'd100);
        for (int e = 1; e <= 1201; e++) begin
            if (e <= 601) spike_b = (e >= 2) && (e % 2 == 0);
            else          spike_b = (e == 700) || (e == 800) || (e == 900);
            tick();
        end
        spike_b = 1'b0;
        ena_b   = 1'b0;
        tick();
        checks++;
        if (exp_rate_b.size() != 0 || exp_isi_b.size() != 0) begin
            failures++;
            $display("FAIL saturation_drain: got %0d rate / %0d isi pending, required 0",
                     exp_rate_b.size(), exp_isi_b.size());
        end
    endtask

    task automatic test_isi_clamp_level();
        start_a();
        // Held-high level in window 0 counts once; the next event lands in window 18.
        for (int w = 0; w <= 18; w++)
            exp_rate_a.push_back({1'b0, ((w == 0) || (w == 18)) ? 8'd1 : 8'd0});
        exp_isi_a.push_back(8'd255);
        for (int e = 1; e <= 305; e++) begin
            spike_a = ((e >= 2) && (e <= 51)) || (e == 302);
            tick();
        end
        spike_a = 1'b0;
        ena_a   = 1'b0;
        tick();
        checks++;
        if (exp_rate_a.size() != 0 || exp_isi_a.size() != 0) begin
            failures++;
            $display("FAIL isi_clamp_drain: got %0d rate / %0d isi pending, required 0",
                     exp_rate_a.size(), exp_isi_a.size());
        end
    endtask

    task automatic test_boundary();
        start_a();
        exp_rate_a.push_back({1'b0, 8'd2});
        exp_rate_a.push_back({1'b0, 8'd0});
        exp_rate_a.push_back({1'b0, 8'd2});
        exp_isi_a.push_back(8'd8);
        exp_isi_a.push_back(8'd17);
        exp_isi_a.push_back(8'd15);
        for (int e = 1; e <= 49; e++) begin
            spike_a = (e == 9) || (e == 17) || (e == 34) || (e == 49);
            tick();
            if (e == 17 || e == 49) begin
                checks++;
                if ({rate_valid_a, isi_valid_a} !== 2'b11) begin
                    failures++;
                    $display("FAIL boundary_coincide_e%0d: got rv=%0d iv=%0d, required rv=1 iv=1",
                             e, rate_valid_a, isi_valid_a);
                end
            end
        end
        spike_a = 1'b0;
        ena_a   = 1'b0;
        tick();
        checks++;
        if (exp_rate_a.size() != 0 || exp_isi_a.size() != 0) begin
            failures++;
            $display("FAIL boundary_drain: got %0d rate / %0d isi pending, required 0",
                     exp_rate_a.size(), exp_isi_a.size());
        end
    endtask

    task automatic test_abort();
        start_a();
        exp_rate_a.push_back({1'b0, 8'd3});
        exp_isi_a.push_back(8'd4);
        exp_isi_a.push_back(8'd4);
        exp_isi_a.push_back(8'd11);
        for (int e = 1; e <= 27; e++) begin
            spike_a = (e == 3) || (e == 7) || (e == 11) || (e == 22);
            tick();
        end
        spike_a = 1'b0;
        ena_a   = 1'b0;
        repeat (20) tick();
        checks++;
        if ({rate_sat_a, rate_a} !== {1'b0, 8'd3}) begin
            failures++;
            $display("FAIL abort_hold: got sat=%0d rate=%0d, required sat=0 rate=3", rate_sat_a, rate_a);
        end
        checks++;
        if (exp_rate_a.size() != 0 || exp_isi_a.size() != 0) begin
            failures++;
            $display("FAIL abort_drain: got %0d rate / %0d isi pending, required 0",
                     exp_rate_a.size(), exp_isi_a.size());
        end
    endtask

    task automatic test_clear();
        start_a();
        exp_rate_a.push_back({1'b0, 8'd2});
        exp_isi_a.push_back(8'd8);
        for (int e = 1; e <= 24; e++) begin
            spike_a = (e == 3) || (e == 8) || (e == 12) || (e == 20);
            clear_a = (e == 8);
            tick();
            if (e == 8) begin
                checks++;
                if ({rate_valid_a, isi_valid_a} !== 2'b00) begin
                    failures++;
                    $display("FAIL clear_cycle_pulse: got rv=%0d iv=%0d, required 0 0",
                             rate_valid_a, isi_valid_a);
                end
            end
        end
        spike_a = 1'b0;
        clear_a = 1'b0;
        ena_a   = 1'b0;
        tick();
        checks++;
        if (exp_rate_a.size() != 0 || exp_isi_a.size() != 0) begin
            failures++;
            $display("FAIL clear_drain: got %0d rate / %0d isi pending, required 0",
                     exp_rate_a.size(), exp_isi_a.size());
        end
    endtask

    task automatic test_reset_midop();
        start_a();
        exp_rate_a.push_back({1'b0, 8'd2});
        exp_isi_a.push_back(8'd4);
        for (int e = 1; e <= 20; e++) begin
            spike_a = (e == 3) || (e == 7);
            tick();
        end
        spike_a = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rate_a, rate_sat_a, rate_valid_a, isi_a, isi_valid_a} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset: got rate=%0d sat=%0d rv=%0d isi=%0d iv=%0d, required all 0",
                     rate_a, rate_sat_a, rate_valid_a, isi_a, isi_valid_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_rate_a.push_back({1'b0, 8'd0});
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 16 || e == 17) begin
                checks++;
                if (rate_valid_a !== (e == 17)) begin
                    failures++;
                    $display("FAIL reset_first_window_e%0d: got rv=%0d, required %0d",
                             e, rate_valid_a, (e == 17));
                end
            end
        end
        ena_a = 1'b0;
        tick();
        checks++;
        if (exp_rate_a.size() != 0 || exp_isi_a.size() != 0) begin
            failures++;
            $display("FAIL reset_midop_drain: got %0d rate / %0d isi pending, required 0",
                     exp_rate_a.size(), exp_isi_a.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fixed_period();
        test_saturation();
        test_isi_clamp_level();
        test_boundary();
        test_abort();
        test_clear();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive-side counterpart of the tinysnn spiking neuron. It takes the neuron's 1-bit spike train and recovers an 8-bit magnitude by counting spike rising edges over a fixed window. In parallel it measures the inter-spike interval (ISI) between consecutive spikes. It sits between the neuron output and the `uio_out`/`uo_out` pins so the chip can read back the value the neuron encoded.

## Interface

Parameters:
- `WINDOW_CYCLES`, default 256: length of one rate window in enabled clock cycles; legal range 2..65535.
- `ISI_W`, default 8: width of the ISI measurement, which saturates at all-ones.

Ports:
- `clk`, input, 1: the single clock for the block.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `ena`, input, 1: enable. Low means idle and clear; high means decode.
- `spike_in`, input, 1: spike train, synchronous to `clk`. Level input; only rising edges count.
- `clear`, input, 1: synchronous restart of the window and ISI tracking. Outputs are not cleared.
- `rate`, output, 8: spike count of the last completed window, saturating at 255.
- `rate_sat`, output, 1: set when the last window's count saturated.
- `rate_valid`, output, 1: one-cycle pulse when `rate` and `rate_sat` update.
- `isi`, output, ISI_W: last measured interval in cycles, saturating.
- `isi_valid`, output, 1: one-cycle pulse when `isi` updates.

## Operation

Edge detection:
- `spike_q` registers `spike_in`.
- A spike event is `spike_in & ~spike_q` while `ena` is high.
- `spike_q` is cleared in IDLE.

State machine:
- **IDLE**: entered on reset and whenever `ena` = 0. The window counter, spike counter, ISI counter and `spike_q` are 0. `rate`, `rate_sat` and `isi` hold their values. Valid pulses are low.
- **ARMED**: entered from IDLE when `ena` = 1, or from any active state on `clear`. The window runs; no spike seen yet. The first event moves to TRACK and starts the ISI counter at 1. No `isi_valid` is produced.
- **TRACK**: the ISI counter increments each cycle, saturating at 2^ISI_W−1. On an event:
  - `isi` takes the counter value;
  - `isi_valid` pulses;
  - the counter reloads to 1.

Window, active in ARMED and TRACK:
- The window counter counts 0..WINDOW_CYCLES−1.
- In the final cycle, `rate` takes the spike count, including an event in that same cycle, and `rate_valid` pulses.
- The spike count restarts at 0, or at 1 if the next window's first cycle has an event.
- The spike counter saturates at 255. `rate_sat` = 1 if saturation was reached during the window.

Priority, highest first:
1. `rst_n` low.
2. `ena` low: go to IDLE.
3. `clear`: go to ARMED with all counters zeroed. An event in the `clear` cycle is ignored, and no valid pulse fires that cycle.
4. Normal operation.

Simultaneous cases:
- When a window end coincides with a spike event, both pulses may fire in the same cycle.
- Deasserting `ena` mid-window discards the partial count. No `rate_valid` fires.

## Timing

- All outputs are registered. Reset values: `rate` = 0, `rate_sat` = 0, `rate_valid` = 0, `isi` = 0, `isi_valid` = 0, state = IDLE.
- Define edge 1 as the first rising edge of `clk` with `ena` = 1. The block leaves IDLE there.
- Window cycles 0..W−1 are edges 2..W+1. `rate_valid` is high in the cycle following edge W+1.
- An event sampled at edge t (`spike_in` = 1 at t, 0 at t−1) is counted at t. For events at t1 < t2 in TRACK, `isi` = t2−t1, clamped to 2^ISI_W−1. `isi_valid` is high in the cycle following edge t2.
- A constantly high `spike_in` produces one event only.
- The maximum event rate is every 2nd cycle.

## Structure

- Shared package `tinysnn_pkg`:
  - the state enum `dec_state_t` (IDLE, ARMED, TRACK);
  - constant `SPIKE_CNT_MAX` = 255.
- One sub-module, `sat_counter` (parameterised width, with `inc`, `load1` and `clr`). It is instantiated for both the spike count and the ISI count.
- Edge detect and the window counter are inline.

## Test plan

- **Fixed period:** WINDOW_CYCLES=16; a 1-cycle pulse every 4 cycles starting at window cycle 0 → `rate` = 4 on each `rate_valid`; `isi` = 4 from the second spike onward. The first spike gives no `isi_valid`.
- **Saturation:** WINDOW_CYCLES=600; `spike_in` toggles every cycle → `rate` = 255 and `rate_sat` = 1. The next window with 3 spikes gives `rate` = 3 and `rate_sat` = 0.
- **ISI clamp and level input:** `spike_in` held high for 50 cycles → exactly one event. Spikes 300 cycles apart with ISI_W=8 → `isi` = 255.
- **Boundary:** events in the last window cycle and in the next window's cycle 0 → counted in the respective windows. `rate_valid` and `isi_valid` are both high in the same cycle.
- **Abort:** `ena` dropped at window cycle 10 → no `rate_valid`, and `rate` holds its previous value. `clear` pulsed with a simultaneous spike → the spike is ignored, and the next window starts counting from the cycle after `clear`.
- **Reset mid-operation:** assert `rst_n` low asynchronously in TRACK → all outputs are 0 immediately, without a clock edge. After release with `ena` = 1, the first `rate_valid` follows W cycles later.
